// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: FIFO-buffered 8N1 UART transmitter for an ASCII character stream.
// Bytes are queued in a small FIFO and serialised LSB first. Each bit lasts
// baud_div+1 clocks, with the divider captured at the start of every frame.
// Optional build macro: PARITY_EN adds an even-parity bit, giving 8E1 (11-bit frames).
module ascii_uart_tx #(
    parameter int DIV_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    output logic                          char_ready,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;

    // Transmit engine
    state_t           state_q, state_d;
    logic             tx_q, tx_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif

    logic             push;
    logic             pop;
    logic             can_start;
    logic             bit_end;
    logic [7:0]       head;

    assign char_ready = (level_q != FULL_LVL);
    assign push       = char_valid && char_ready;
    assign can_start  = ena && (level_q != '0);
    assign bit_end    = (cnt_q == div_q);
    assign head       = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = (level_q != '0) || (state_q != S_IDLE);
    assign fifo_level = level_q;

    // FIFO pointer and occupancy next-state; push and pop together keep the level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO data array; contents are don't-care while the level says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= char_in;
        end
    end

    // Frame sequencer next-state; tx is computed one edge ahead so it is a clean flop output
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
`ifdef PARITY_EN
        par_d     = par_q;
`endif
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (can_start) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef PARITY_EN
                        state_d   = S_PARITY;
                        tx_d      = par_q;
`else
                        state_d   = S_STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (can_start) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop always starts a new frame: load the byte and freeze the divider
        if (pop) begin
            state_d   = S_START;
            tx_d      = 1'b0;
            shift_d   = head;
            div_d     = baud_div;
            cnt_d     = '0;
            bit_idx_d = '0;
`ifdef PARITY_EN
            par_d     = ^head;
`endif
        end
    end

    // State registers for FIFO bookkeeping and the frame sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
`ifdef PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
`ifdef PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx: scoreboard bench for ascii_uart_tx. Accepted bytes are queued as
// expected frames; a line monitor decodes tx and compares every bit and its duration.
module tb_ascii_uart_tx;

    localparam int DIV_W      = 12;
    localparam int FIFO_DEPTH = 4;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        ena = 1'b0;
    logic [7:0]                  char_in = 8'h00;
    logic                        char_valid = 1'b0;
    logic                        char_ready;
    logic [DIV_W-1:0]            baud_div = '0;
    logic                        tx;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0]       exp_q [$];
    int               starts [$];
    logic [DIV_W-1:0] prev_div = '0;

    ascii_uart_tx #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .baud_div   (baud_div),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_div <= baud_div;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Offer one byte; record it as expected once the handshake completes
    task automatic push_byte(input logic [7:0] b, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(negedge clk);
        char_in    = b;
        char_valid = 1'b1;
        while (!char_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!char_ready) begin
            check("push_ready_timeout", t, 0);
            char_valid = 1'b0;
            return;
        end
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        acc        = cyc;
        char_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", int'(t < limit), 1);
    endtask

    // Line monitor: each falling tx while idle begins a frame checked against the queue
    initial begin : monitor
        logic [10:0] fb;
        logic [7:0]  b;
        int          d;
        bit          ok;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                starts.push_back(cyc);
                d = int'(prev_div);
                check("frame_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() == 0) begin
                    repeat (NB * (d + 1) - 1) @(negedge clk);
                end else begin
                    b       = exp_q.pop_front();
                    fb      = frame_bits(b);
                    aborted = 1'b0;
                    for (int i = 0; i < NB && !aborted; i++) begin
                        ok = 1'b1;
                        for (int k = 0; k <= d; k++) begin
                            if (i != 0 || k != 0) @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx !== fb[i]) ok = 1'b0;
                        end
                        if (!aborted) check($sformatf("frame_%02h_bit%0d", b, i), int'(ok), 1);
                    end
                    if (aborted) exp_q.delete();
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         acc;
        int         base;
        int         t;
        logic [7:0] guat [0:8];
        logic [7:0] rb;

        guat = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};

        // Reset state while held
        #12;
        check("rst_tx", int'(tx), 1);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(char_ready), 1);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tx", int'(tx), 1);

        // Single 'G' at 4 clocks per bit, latency from accept to start bit
        ena      = 1'b1;
        baud_div = 3;
        base     = starts.size();
        push_byte(8'h47, acc);
        wait_drain(300);
        check("g_frame_count", starts.size(), base + 1);
        if (starts.size() > base) check("g_start_latency", starts[base], acc + 1);
        check("g_idle_tx", int'(tx), 1);
        check("g_idle_busy", int'(busy), 0);

        // Disabled: FIFO fills to depth, fifth byte held, line stays idle
        ena = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) push_byte(8'($urandom_range(0, 255)), acc);
        @(negedge clk);
        char_in    = 8'h35;
        char_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("full_ready", int'(char_ready), 0);
        check("full_level", int'(fifo_level), FIFO_DEPTH);
        check("full_tx", int'(tx), 1);
        check("full_busy", int'(busy), 1);
        char_valid = 1'b0;
        ena        = 1'b1;
        push_byte(8'h35, acc);
        wait_drain(2000);

        // "Guatemala" at 1 clock per bit, frames contiguous
        baud_div = 0;
        base     = starts.size();
        for (int i = 0; i < 9; i++) push_byte(guat[i], acc);
        wait_drain(500);
        check("guat_frames", starts.size(), base + 9);
        for (int i = 1; i < 9; i++)
            if (starts.size() > base + i)
                check($sformatf("guat_gap%0d", i), starts[base+i] - starts[base+i-1], NB);

        // Divider change mid-frame applies only from the next frame
        baud_div = 3;
        base     = starts.size();
        push_byte(8'h55, acc);
        push_byte(8'hA3, acc);
        t = 0;
        while (starts.size() <= base && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        baud_div = 7;
        wait_drain(1000);
        check("div_frames", starts.size(), base + 2);
        if (starts.size() > base + 1) check("div_first_len", starts[base+1] - starts[base], NB * 4);

`ifdef PARITY_EN
        // Parity frames: 0x47 even parity 0, 0x51 parity 1, 22 clocks each
        baud_div = 1;
        base     = starts.size();
        push_byte(8'h47, acc);
        push_byte(8'h51, acc);
        wait_drain(500);
        check("par_frames", starts.size(), base + 2);
        if (starts.size() > base + 1) check("par_len", starts[base+1] - starts[base], 22);
`endif

        // Randomized traffic: random bytes, dividers, enable and gaps
        for (int n = 0; n < 24; n++) begin
            baud_div = DIV_W'($urandom_range(0, 3));
            ena      = ($urandom_range(0, 3) != 0);
            if (fifo_level == FIFO_DEPTH) ena = 1'b1;
            rb = 8'($urandom_range(0, 255));
            push_byte(rb, acc);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        ena = 1'b1;
        wait_drain(20000);

        // Reset in the DATA state of 0x51 with two bytes still queued
        baud_div = 3;
        base     = starts.size();
        push_byte(8'h51, acc);
        push_byte(8'($urandom_range(0, 255)), acc);
        push_byte(8'($urandom_range(0, 255)), acc);
        t = 0;
        while (starts.size() <= base && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (7) @(negedge clk);
        check("pre_rst_level", int'(fifo_level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", int'(tx), 1);
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_ready", int'(char_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = starts.size();
        repeat (100) @(negedge clk);
        check("post_rst_no_frames", starts.size(), base);
        check("post_rst_tx", int'(tx), 1);
        check("post_rst_busy", int'(busy), 0);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
